// File: rtl/shift_reg_seq.sv
// Sequencer for a WIDTH-stage parallel-load/serial-shift register.
// Loads one accepted word, then issues WIDTH shift enables paced by a DIV-clock bit-period divider.
module shift_reg_seq #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV   = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         abort_i,
  output logic                         ready_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         move_load_o,
  output logic                         en_o,
  output logic [WIDTH-1:0]             d_o,
  output logic [$clog2(WIDTH+1)-1:0]   bit_cnt_o
);

  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_q;
  logic             tick;

  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  // en_o is the only output that also looks at abort_i, so an abort suppresses the pending update.
  always_comb begin
    state_nxt   = state;
    ready_o     = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    move_load_o = 1'b1;
    en_o        = 1'b0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i) state_nxt = LOAD;
      end
      LOAD: begin
        busy_o      = 1'b1;
        move_load_o = 1'b0;
        if (abort_i) begin
          state_nxt = IDLE;
        end else begin
          en_o      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy_o = 1'b1;
        if (abort_i) begin
          state_nxt = IDLE;
        end else if (tick) begin
          en_o = 1'b1;
          if (bit_cnt_o == CNT_LAST) state_nxt = DONE;
        end
      end
      DONE: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      d_o       <= '0;
      bit_cnt_o <= '0;
      div_q     <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) d_o <= data_i;
        LOAD: begin
          if (!abort_i) begin
            div_q     <= '0;
            bit_cnt_o <= '0;
          end
        end
        SHIFT: begin
          if (!abort_i) begin
            if (tick) begin
              div_q     <= '0;
              bit_cnt_o <= bit_cnt_o + 1'b1;
            end else begin
              div_q <= div_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_reg_seq.sv
// Bench for shift_reg_seq: DIV=4 and DIV=1 instances share stimulus and are checked
// against a cycle-index model derived from the load/shift/done timing rules.
module tb_shift_reg_seq;

  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, abort;
  logic [W-1:0] data;
  logic         ready[2], busy[2], done[2], move[2], en[2];
  logic [W-1:0] dq[2];
  logic [2:0]   cnt[2];
  logic [W-1:0] q;

  shift_reg_seq #(.WIDTH(W), .DIV(4)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .data_i(data), .abort_i(abort),
    .ready_o(ready[0]), .busy_o(busy[0]), .done_o(done[0]), .move_load_o(move[0]),
    .en_o(en[0]), .d_o(dq[0]), .bit_cnt_o(cnt[0])
  );

  shift_reg_seq #(.WIDTH(W), .DIV(1)) u_dut_div1 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .data_i(data), .abort_i(abort),
    .ready_o(ready[1]), .busy_o(busy[1]), .done_o(done[1]), .move_load_o(move[1]),
    .en_o(en[1]), .d_o(dq[1]), .bit_cnt_o(cnt[1])
  );

  // Register being sequenced (DIV=4 instance), serial input tied low.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     q <= '0;
    else if (en[0]) q <= move[0] ? {q[W-2:0], 1'b0} : dq[0];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dv(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic string tg(input string s, input int i);
    return $sformatf("%s_dut%0d", s, i);
  endfunction

  // m_t: cycles since the accepting edge (0 = idle, 1 = load, last+1 = done)
  int           m_t[2];
  int           m_cnt[2];
  logic [W-1:0] m_data[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_t[i]    = 0;
      m_cnt[i]  = 0;
      m_data[i] = '0;
    end
  endtask

  task automatic compare_all();
    logic [W-1:0] eq;
    for (int i = 0; i < 2; i++) begin
      int d    = dv(i);
      int t    = m_t[i];
      int last = 1 + W * d;
      bit e_en = !abort && (t == 1 || (t >= 2 && t <= last && (t - 1) % d == 0));
      check(tg("ready", i), ready[i], t == 0);
      check(tg("busy", i), busy[i], t >= 1 && t <= last);
      check(tg("done", i), done[i], t == last + 1);
      check(tg("move_load", i), move[i], t != 1);
      check(tg("en", i), en[i], e_en);
      check(tg("d_o", i), dq[i], m_data[i]);
      check(tg("bit_cnt", i), cnt[i], m_cnt[i]);
    end
    if (m_t[0] >= 2 && m_t[0] <= 1 + W * 4) begin
      eq = m_data[0] << m_cnt[0];
      check("reg_q", q, eq);
    end
  endtask

  task automatic model_advance();
    for (int i = 0; i < 2; i++) begin
      int d    = dv(i);
      int t    = m_t[i];
      int last = 1 + W * d;
      if (t == 0) begin
        if (start) begin
          m_t[i]    = 1;
          m_data[i] = data;
        end
      end else if (t <= last) begin
        if (abort) begin
          m_t[i] = 0;
        end else begin
          m_cnt[i] = (t == 1) ? 0 : (t - 1) / d;
          m_t[i]   = t + 1;
        end
      end else begin
        m_t[i] = 0;
      end
    end
  endtask

  task automatic step(input logic s, input logic a, input logic [W-1:0] d);
    @(negedge clk);
    start = s;
    abort = a;
    data  = d;
    #1;
    compare_all();
    model_advance();
  endtask

  task automatic idle_steps(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, W'($urandom));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    start = 1'b0;
    abort = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    data  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;

    // nominal word, data changing while busy
    step(1'b1, 1'b0, 4'b1011);
    idle_steps(20);

    // abort in cycle 9, restart in cycle 10
    step(1'b1, 1'b0, 4'b0110);
    idle_steps(8);
    step(1'b0, 1'b1, 4'b0000);
    step(1'b1, 1'b0, 4'b1101);
    idle_steps(22);

    // start with abort in IDLE, then abort during DONE
    step(1'b1, 1'b1, 4'b1001);
    idle_steps(17);
    step(1'b0, 1'b1, 4'b0101);
    idle_steps(4);

    // start held high with changing data
    for (int k = 0; k < 60; k++) step(1'b1, 1'b0, W'($urandom));
    idle_steps(22);

    // asynchronous reset during cycle 10 of a word
    step(1'b1, 1'b0, 4'b1111);
    idle_steps(9);
    do_reset();
    idle_steps(25);

    for (int k = 0; k < 2000; k++)
      step(($urandom % 3) == 0, ($urandom % 16) == 0, W'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
